// File: rtl/tmem_pkg.sv
// Shared types and constants for the tagged-memory bus responder.
package tmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    LOCK = 2'd2
  } tmem_state_e;

  localparam int TMEM_AW_DEFAULT = 20;
  localparam int MAX_READ_LAT    = 4;
  localparam int DATA_W          = 64;
  localparam int TAG_W           = 8;

endpackage

// File: rtl/tmem_rdpipe.sv
// Fixed-latency read return pipe; each stage loads only when a valid read enters it.
module tmem_rdpipe #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] data_out,
  output logic [TAG_W-1:0]  tag_out
);

  logic [STAGES-1:0] vld_p;
  logic [DATA_W-1:0] data_p [STAGES];
  logic [TAG_W-1:0]  tag_p  [STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= vld_in;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Data advances only behind a valid bit, so the last stage holds between reads
  always_ff @(posedge clk) begin
    if (vld_in) begin
      data_p[0] <= data_in;
      tag_p[0]  <= tag_in;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (vld_p[i-1]) begin
        data_p[i] <= data_p[i-1];
        tag_p[i]  <= tag_p[i-1];
      end
    end
  end

  assign vld_out  = vld_p[STAGES-1];
  assign data_out = data_p[STAGES-1];
  assign tag_out  = tag_p[STAGES-1];

endmodule

// File: rtl/tmem_responder.sv
// Memory-side responder for the multiplexed tagged address/data bus with atomic sequencing.
module tmem_responder
  import tmem_pkg::*;
#(
  parameter int AW       = TMEM_AW_DEFAULT,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_ad,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_astb,
  input  logic              i_atomic,
  input  logic              i_rd,
  input  logic              i_wr,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  output logic [AW-1:0]     o_waddr,
  output logic              o_err
);

  localparam int STAGES = (READ_LAT < 1) ? 1 :
                          (READ_LAT > MAX_READ_LAT) ? MAX_READ_LAT : READ_LAT;

  logic [DATA_W-1:0] mem [2**AW];
  logic [TAG_W-1:0]  tag [2**AW];

  tmem_state_e state_q, state_d;
  logic atomic_q, atomic_d;
  logic err_d, do_rd, do_wr;
  logic out_seen_q;
  logic pipe_vld;
  logic [DATA_W-1:0] pipe_data;
  logic [TAG_W-1:0]  pipe_tag;

  always_comb begin
    state_d  = state_q;
    atomic_d = atomic_q;
    err_d    = 1'b0;
    do_rd    = 1'b0;
    do_wr    = 1'b0;
    if (i_astb) begin
      // i_ad carries an address this cycle, so any data op alongside it is dropped
      state_d  = ADDR;
      atomic_d = i_atomic;
      err_d    = (state_q == LOCK) || i_rd || i_wr;
    end else if (i_rd && i_wr) begin
      err_d = 1'b1;
    end else if (i_rd) begin
      case (state_q)
        ADDR: begin
          do_rd = 1'b1;
          if (atomic_q) state_d = LOCK;
        end
        default: err_d = 1'b1;
      endcase
    end else if (i_wr) begin
      case (state_q)
        ADDR: do_wr = 1'b1;
        LOCK: begin
          do_wr    = 1'b1;
          state_d  = ADDR;
          atomic_d = 1'b0;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      atomic_q   <= 1'b0;
      o_waddr    <= '0;
      o_err      <= 1'b0;
      out_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      atomic_q   <= atomic_d;
      o_err      <= err_d;
      out_seen_q <= out_seen_q | pipe_vld;
      if (i_astb) o_waddr <= i_ad[AW-1:0];
    end
  end

  // Storage is never reset so contents survive a bus reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[o_waddr] <= i_ad;
      tag[o_waddr] <= i_tag;
    end
  end

  tmem_rdpipe #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .STAGES (STAGES)
  ) u_rdpipe (
    .clk      (clk),
    .reset    (reset),
    .vld_in   (do_rd),
    .data_in  (mem[o_waddr]),
    .tag_in   (tag[o_waddr]),
    .vld_out  (pipe_vld),
    .data_out (pipe_data),
    .tag_out  (pipe_tag)
  );

  // Outputs read as zero until the first return after reset, then hold the last return
  assign o_valid = pipe_vld;
  assign o_data  = (out_seen_q || pipe_vld) ? pipe_data : '0;
  assign o_tag   = (out_seen_q || pipe_vld) ? pipe_tag  : '0;

endmodule

// File: tb/tb_tmem_responder.sv
// Randomized bench: three responders (latency 1/2/3) on one bus against a transaction-level model.
module tb_tmem_responder;

  localparam int AW = 12;
  localparam int NW = 2**AW;
  localparam int ND = 3;

  typedef struct {
    int          due;
    logic [63:0] d;
    logic [7:0]  t;
  } rd_t;

  logic        clk;
  logic        reset;
  logic [63:0] i_ad;
  logic [7:0]  i_tag;
  logic        i_astb, i_atomic, i_rd, i_wr;

  logic [63:0]   o_data_a  [ND];
  logic [7:0]    o_tag_a   [ND];
  logic          o_valid_a [ND];
  logic [AW-1:0] o_waddr_a [ND];
  logic          o_err_a   [ND];

  int lat [ND] = '{1, 2, 3};

  tmem_responder #(.AW(AW), .READ_LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
    .i_atomic(i_atomic), .i_rd(i_rd), .i_wr(i_wr), .o_data(o_data_a[0]),
    .o_tag(o_tag_a[0]), .o_valid(o_valid_a[0]), .o_waddr(o_waddr_a[0]), .o_err(o_err_a[0]));
  tmem_responder #(.AW(AW), .READ_LAT(2)) u_l2 (
    .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
    .i_atomic(i_atomic), .i_rd(i_rd), .i_wr(i_wr), .o_data(o_data_a[1]),
    .o_tag(o_tag_a[1]), .o_valid(o_valid_a[1]), .o_waddr(o_waddr_a[1]), .o_err(o_err_a[1]));
  tmem_responder #(.AW(AW), .READ_LAT(3)) u_l3 (
    .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
    .i_atomic(i_atomic), .i_rd(i_rd), .i_wr(i_wr), .o_data(o_data_a[2]),
    .o_tag(o_tag_a[2]), .o_valid(o_valid_a[2]), .o_waddr(o_waddr_a[2]), .o_err(o_err_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory image, bus-level address/lock status, pending returns
  logic [63:0]   mem_m [NW];
  logic [7:0]    tag_m [NW];
  bit            have_m, locked_m, atom_m;
  logic [AW-1:0] waddr_m;
  logic [63:0]   last_d [ND];
  logic [7:0]    last_t [ND];
  rd_t           pend [ND][$];
  int            cyc;
  int            n_tests, n_fail;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic backdoor(input int a, input logic [63:0] d, input logic [7:0] t);
    u_l1.mem[a] = d; u_l1.tag[a] = t;
    u_l2.mem[a] = d; u_l2.tag[a] = t;
    u_l3.mem[a] = d; u_l3.tag[a] = t;
    mem_m[a] = d; tag_m[a] = t;
  endtask

  task automatic check_outputs(input bit err_exp);
    bit vexp;
    for (int k = 0; k < ND; k++) begin
      vexp = 1'b0;
      if (pend[k].size() > 0 && pend[k][0].due == cyc) begin
        vexp = 1'b1;
        last_d[k] = pend[k][0].d;
        last_t[k] = pend[k][0].t;
        void'(pend[k].pop_front());
      end
      check($sformatf("lat%0d_valid", lat[k]), {63'd0, o_valid_a[k]}, {63'd0, vexp});
      check($sformatf("lat%0d_data", lat[k]), o_data_a[k], last_d[k]);
      check($sformatf("lat%0d_tag", lat[k]), {56'd0, o_tag_a[k]}, {56'd0, last_t[k]});
      check($sformatf("lat%0d_err", lat[k]), {63'd0, o_err_a[k]}, {63'd0, err_exp});
      check($sformatf("lat%0d_waddr", lat[k]), {{(64-AW){1'b0}}, o_waddr_a[k]},
            {{(64-AW){1'b0}}, waddr_m});
    end
  endtask

  // One bus cycle: apply inputs, predict the outcome of the coming edge, check after it
  task automatic bus(input bit astb, input bit atomic, input bit rd, input bit wr,
                     input logic [63:0] ad, input logic [7:0] tg);
    bit err, rd_ok;
    logic [63:0] rdat;
    logic [7:0]  rtag;
    i_astb = astb; i_atomic = atomic; i_rd = rd; i_wr = wr; i_ad = ad; i_tag = tg;
    err = 1'b0; rd_ok = 1'b0; rdat = '0; rtag = '0;
    if (astb) begin
      err = locked_m || rd || wr;
      waddr_m = ad[AW-1:0];
      atom_m = atomic; have_m = 1'b1; locked_m = 1'b0;
    end else if (rd && wr) begin
      err = 1'b1;
    end else if (rd) begin
      if (!have_m || locked_m) err = 1'b1;
      else begin
        rd_ok = 1'b1;
        rdat = mem_m[waddr_m]; rtag = tag_m[waddr_m];
        if (atom_m) locked_m = 1'b1;
      end
    end else if (wr) begin
      if (!have_m) err = 1'b1;
      else begin
        mem_m[waddr_m] = ad; tag_m[waddr_m] = tg;
        if (locked_m) begin locked_m = 1'b0; atom_m = 1'b0; end
      end
    end
    @(posedge clk);
    cyc++;
    if (rd_ok)
      for (int k = 0; k < ND; k++) pend[k].push_back('{cyc + lat[k] - 1, rdat, rtag});
    #1;
    check_outputs(err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
  endtask

  // Called #1 after an edge; asserts reset asynchronously for one edge
  task automatic do_reset();
    i_astb = 1'b0; i_atomic = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
    reset = 1'b0;
    #1;
    have_m = 1'b0; locked_m = 1'b0; atom_m = 1'b0; waddr_m = '0;
    for (int k = 0; k < ND; k++) begin
      pend[k].delete();
      last_d[k] = '0; last_t[k] = '0;
    end
    check_outputs(1'b0);
    @(posedge clk);
    cyc++;
    #1;
    check_outputs(1'b0);
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    reset = 1'b0;
    i_ad = '0; i_tag = '0; i_astb = 1'b0; i_atomic = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
    for (int a = 0; a < NW; a++) backdoor(a, {$urandom, $urandom}, 8'($urandom));
    @(posedge clk); cyc++; #1;
    do_reset();

    // Backdoor read
    backdoor('h12, 64'h0123_4567_89AB_CDEF, 8'h35);
    bus(1, 0, 0, 0, 64'h12, 8'h00);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    idle(4);

    // Write then read
    bus(1, 0, 0, 0, 64'h400, 8'h00);
    bus(0, 0, 0, 1, 64'hDEAD_BEEF_0000_0001, 8'h07);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    idle(4);

    // Atomic sequence
    bus(1, 1, 0, 0, 64'h5, 8'h00);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    bus(0, 0, 0, 1, 64'h1, 8'h11);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    idle(4);
    check("mem5_backdoor", u_l2.mem[5], 64'h1);

    // Protocol errors
    do_reset();
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    idle(4);
    bus(1, 0, 0, 0, 64'h20, 8'h00);
    bus(0, 0, 1, 1, 64'hAAAA, 8'hAA);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    bus(1, 0, 0, 1, 64'h30, 8'h33);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    bus(1, 1, 0, 0, 64'h31, 8'h00);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    bus(1, 0, 0, 0, 64'h32, 8'h00);
    idle(4);

    // Back-to-back reads with interleaved and pure streams
    bus(1, 0, 0, 0, 64'h40, 8'h00);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    bus(0, 0, 0, 1, 64'h4444_0001, 8'h41);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    bus(0, 0, 0, 1, 64'h4444_0002, 8'h42);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    for (int i = 0; i < 4; i++) bus(0, 0, 1, 0, 64'h0, 8'h00);
    idle(4);

    // Reset one cycle after a read
    bus(1, 0, 0, 0, 64'h12, 8'h00);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    idle(1);
    do_reset();
    idle(3);
    bus(1, 0, 0, 0, 64'h12, 8'h00);
    bus(0, 0, 1, 0, 64'h0, 8'h00);
    idle(4);

    // Random traffic over a small address pool
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1) do_reset();
      else if (r < 16)
        bus(1, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            64'($urandom_range(0, 15) * 3), 8'd0);
      else if (r < 50) bus(0, 0, 1, $urandom_range(0, 9) == 0, {$urandom, $urandom}, 8'($urandom));
      else if (r < 75) bus(0, 0, 0, 1, {$urandom, $urandom}, 8'($urandom));
      else idle(1);
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tmem_responder.md
Name: tmem_responder

Overview:
- Bus responder (memory side) for the CPU's multiplexed, tagged address/data bus.
- It latches word addresses from address strobes and executes reads and writes against an internal array of 64-bit data words plus 8-bit tags.
- Returns read data after a fixed latency and enforces read-modify-write (atomic) sequencing.
- Sits between the cpu output bus (o_ad/o_tag/o_astb/o_atomic/o_rd/o_wr) and the cpu inputs (i_data/i_tag); replaces the behavioural RAM in system benches.

Parameters:
- AW, 20, word-address width; array depth 2**AW.
- READ_LAT, 1, cycles from the rd cycle to o_valid; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_ad  input  64  address (on astb cycle) or write data (on wr cycle).
- i_tag  input  8  write tag, sampled on wr cycle.
- i_astb  input  1  address strobe.
- i_atomic  input  1  read-modify-write flag, sampled with i_astb.
- i_rd  input  1  read request.
- i_wr  input  1  write request.
- o_data  output  64  read data.
- o_tag  output  8  read tag.
- o_valid  output  1  one-cycle pulse; o_data/o_tag are valid.
- o_waddr  output  AW  currently latched word address (for tracer).
- o_err  output  1  one-cycle protocol-violation pulse.

Behaviour:
- Storage: internal arrays named mem [2**AW][64] and tag [2**AW][8], writable hierarchically by benches. Reset does not clear them.
- Reset (reset low, async):
  - o_data=0, o_tag=0, o_valid=0, o_waddr=0, o_err=0.
  - state=IDLE; read pipeline flushed.
  - Reset mid-read means no o_valid is ever issued for that read.
- State machine states:
  - IDLE: no address latched.
  - ADDR: address latched.
  - LOCK: atomic read done, write pending.
- i_astb=1, any state: o_waddr <= i_ad[AW-1:0]; latch i_atomic; next state ADDR.
  - If in LOCK: o_err pulses and the lock is dropped.
  - If i_rd or i_wr is also asserted in that cycle: o_err pulses and the op is ignored (i_ad carries an address, not data).
- ADDR + i_rd:
  - Sample mem/tag[o_waddr] at this edge.
  - o_valid pulses exactly READ_LAT cycles later, with o_data/o_tag updated on that same edge.
  - If the latched atomic flag is 1, next state is LOCK; otherwise stay in ADDR.
- ADDR + i_wr: mem[o_waddr] <= i_ad, tag[o_waddr] <= i_tag; stay in ADDR.
- LOCK + i_wr: write as in ADDR; next state ADDR; atomic flag cleared.
- LOCK + i_rd: o_err pulses; no read is performed; stay in LOCK.
- The address does not auto-increment. Repeated rd/wr cycles target the same word.
- i_rd and i_wr in the same cycle: o_err pulses, both ignored, state unchanged.
- i_rd or i_wr in IDLE: o_err pulses, op ignored.
- Write followed by read in the next cycle: the read returns the new data, because the write is committed at the earlier edge.
- Back-to-back reads: one read per cycle accepted. The pipeline is fully pipelined; each rd yields exactly one o_valid pulse in order.
- o_data/o_tag hold their last values between valid pulses.
- o_err is registered: it asserts on the edge at which the violating cycle is sampled and clears on the next edge unless another violation occurs.

Decomposition:
- Package tmem_pkg:
  - state enum: IDLE, ADDR, LOCK.
  - default AW constant.
  - MAX_READ_LAT=4.
- Sub-module tmem_rdpipe: READ_LAT-deep shift register of {valid, data, tag}. It has the same async active-low reset and clears only the valid bits.
- Top-level tmem_responder contains the FSM, address latch, arrays and error logic.

Test Plan:
- Backdoor mem[0x00012]=64'h0123_4567_89AB_CDEF, tag=8'h35; drive astb with i_ad=0x12, then rd next cycle -> o_valid one cycle later (READ_LAT=1) with that data/tag; o_waddr=0x12; o_err stays 0.
- Drive astb with addr 0x400, then wr with i_ad=64'hDEAD_BEEF_0000_0001, tag=8'h07, then rd -> o_valid returns 64'hDEAD_BEEF_0000_0001/8'h07. Repeat with READ_LAT=3 -> valid arrives exactly 3 cycles after rd.
- Atomic sequence: astb(atomic=1, addr 5), rd, rd -> second rd gives an o_err pulse and no second valid. Then wr 64'h1 -> mem[5]=1 and state returns to ADDR; a further rd is accepted with o_err=0.
- Protocol errors:
  - rd after reset with no astb -> o_err=1 for one cycle, no o_valid.
  - rd&wr together -> o_err, memory unchanged.
  - astb with wr -> o_err, address latched, no write.
- Four back-to-back rd cycles with READ_LAT=2, with data changed in between by wr cycles to the same address -> four consecutive o_valid pulses, each returning the value current at its rd edge.
- Assert reset low one cycle after rd with READ_LAT=3 -> o_valid never pulses; all outputs 0; memory contents preserved, as checked by a subsequent read.
